// File: rtl/axis_adder_pkg.sv
// Shared constants and types for the AXI-Stream adder datapath.
package axis_adder_pkg;
  localparam int unsigned DEFAULT_WIDTH = 4;
  localparam int unsigned BUF_DEPTH     = 2;
  localparam int unsigned CNT_W         = 2;

  typedef enum logic [CNT_W-1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_t;
endpackage

// File: rtl/axis_skid_fifo2.sv
// Two-entry input FIFO with registered ready and an empty flag for the pairing logic.
module axis_skid_fifo2
  import axis_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_tdata,
  input  logic             in_tvalid,
  output logic             in_tready,
  input  logic             pop,
  output logic [WIDTH-1:0] out_data,
  output logic             out_empty
);

  occ_t             occ, occ_next;
  logic [WIDTH-1:0] slot0, slot1;
  logic             push;
  logic             wr_hi;

  assign push      = in_tvalid && in_tready;
  assign wr_hi     = (occ == OCC_ONE) && !pop;
  assign out_data  = slot0;
  assign out_empty = (occ == OCC_EMPTY);

  always_comb begin
    occ_next = occ;
    unique case ({push, pop})
      2'b10:   occ_next = (occ == OCC_EMPTY) ? OCC_ONE : OCC_FULL;
      2'b01:   occ_next = (occ == OCC_FULL) ? OCC_ONE : OCC_EMPTY;
      default: occ_next = occ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ       <= OCC_EMPTY;
      in_tready <= 1'b0;
    end else begin
      occ       <= occ_next;
      in_tready <= (occ_next != OCC_FULL);
    end
  end

  // Head always lives in slot0; a pop shifts slot1 down, and a simultaneous
  // write into slot0 (occupancy one, push+pop) overrides that shift.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot0 <= '0;
      slot1 <= '0;
    end else begin
      if (pop)
        slot0 <= slot1;
      if (push) begin
        if (wr_hi)
          slot1 <= in_tdata;
        else
          slot0 <= in_tdata;
      end
    end
  end

endmodule

// File: rtl/axis_operand_join.sv
// Pairs two AXI-Stream operand streams beat-by-beat into one registered master stream.
module axis_operand_join
  import axis_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] s1_tdata,
  input  logic             s1_tvalid,
  output logic             s1_tready,
  input  logic [WIDTH-1:0] s2_tdata,
  input  logic             s2_tvalid,
  output logic             s2_tready,
  output logic [WIDTH-1:0] data1_o,
  output logic [WIDTH-1:0] data2_o,
  output logic             m_tvalid,
  input  logic             m_tready
);

  logic [WIDTH-1:0] head1, head2;
  logic             empty1, empty2;
  logic             load;

  assign load = !empty1 && !empty2 && (!m_tvalid || m_tready);

  axis_skid_fifo2 #(.WIDTH(WIDTH)) u_buf1 (
    .clk       (clk),
    .reset     (reset),
    .in_tdata  (s1_tdata),
    .in_tvalid (s1_tvalid),
    .in_tready (s1_tready),
    .pop       (load),
    .out_data  (head1),
    .out_empty (empty1)
  );

  axis_skid_fifo2 #(.WIDTH(WIDTH)) u_buf2 (
    .clk       (clk),
    .reset     (reset),
    .in_tdata  (s2_tdata),
    .in_tvalid (s2_tvalid),
    .in_tready (s2_tready),
    .pop       (load),
    .out_data  (head2),
    .out_empty (empty2)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data1_o  <= '0;
      data2_o  <= '0;
      m_tvalid <= 1'b0;
    end else if (load) begin
      data1_o  <= head1;
      data2_o  <= head2;
      m_tvalid <= 1'b1;
    end else if (m_tready) begin
      m_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_operand_join.sv
// Directed and randomized checks of axis_operand_join against a queue-based reference model.
module tb_axis_operand_join;
  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] s1_tdata, s2_tdata;
  logic         s1_tvalid, s2_tvalid, s1_tready, s2_tready;
  logic [W-1:0] data1_o, data2_o;
  logic         m_tvalid, m_tready;

  always #5 clk = ~clk;

  axis_operand_join #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .s1_tdata  (s1_tdata),
    .s1_tvalid (s1_tvalid),
    .s1_tready (s1_tready),
    .s2_tdata  (s2_tdata),
    .s2_tvalid (s2_tvalid),
    .s2_tready (s2_tready),
    .data1_o   (data1_o),
    .data2_o   (data2_o),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready)
  );

  int unsigned compared = 0;
  int unsigned mismatched = 0;

  // reference model: buffered beats, held output pair, expected readies
  logic [W-1:0] b1[$], b2[$];
  logic [W-1:0] md1, md2;
  logic         mov, mrdy1, mrdy2;

  // stimulus: pending beats per input, enables, downstream ready
  logic [W-1:0] p1[$], p2[$], c1[$], c2[$];
  bit           en1, en2, mr;
  logic [2*W-1:0] got[$];
  int unsigned  hs_count;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("s1_tready", W'(s1_tready), W'(mrdy1));
    check("s2_tready", W'(s2_tready), W'(mrdy2));
    check("m_tvalid", W'(m_tvalid), W'(mov));
    check("data1_o", data1_o, md1);
    check("data2_o", data2_o, md2);
  endtask

  task automatic model_reset();
    b1.delete(); b2.delete();
    md1 = '0; md2 = '0;
    mov = 1'b0; mrdy1 = 1'b0; mrdy2 = 1'b0;
  endtask

  task automatic tick();
    logic tx1, tx2, ld;
    s1_tvalid = en1 && (p1.size() > 0);
    s1_tdata  = s1_tvalid ? p1[0] : W'($urandom);
    s2_tvalid = en2 && (p2.size() > 0);
    s2_tdata  = s2_tvalid ? p2[0] : W'($urandom);
    m_tready  = mr;
    #3;
    if (m_tvalid && m_tready) begin
      got.push_back({data1_o, data2_o});
      hs_count++;
    end
    tx1 = s1_tvalid && mrdy1;
    tx2 = s2_tvalid && mrdy2;
    ld  = (b1.size() > 0) && (b2.size() > 0) && (!mov || mr);
    @(posedge clk);
    if (ld) begin
      md1 = b1.pop_front();
      md2 = b2.pop_front();
      mov = 1'b1;
    end else if (mr) begin
      mov = 1'b0;
    end
    if (tx1) begin b1.push_back(s1_tdata); p1.delete(0); end
    if (tx2) begin b2.push_back(s2_tdata); p2.delete(0); end
    mrdy1 = (b1.size() < 2);
    mrdy2 = (b2.size() < 2);
    #1;
    check_all();
  endtask

  task automatic do_reset(input int unsigned cycles);
    reset = 1'b1;
    s1_tvalid = 1'b0; s2_tvalid = 1'b0;
    en1 = 0; en2 = 0;
    p1.delete(); p2.delete();
    model_reset();
    #1;
    check_all();
    for (int unsigned i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      check_all();
    end
    reset = 1'b0;
  endtask

  task automatic check_pairs(input string tag);
    check({tag, "_count"}, W'(got.size()), W'(c1.size()));
    if (got.size() == c1.size())
      for (int unsigned i = 0; i < c1.size(); i++) begin
        check({tag, "_d1"}, got[i][2*W-1:W], c1[i]);
        check({tag, "_d2"}, got[i][W-1:0], c2[i]);
      end
  endtask

  initial begin
    reset = 1'b1;
    s1_tvalid = 1'b0; s2_tvalid = 1'b0; m_tready = 1'b0;
    s1_tdata = '0; s2_tdata = '0;
    en1 = 0; en2 = 0; mr = 0; hs_count = 0;
    model_reset();
    @(posedge clk);
    #1;

    // reset held for 3 clocks, ready one clock after release
    do_reset(3);
    tick();
    check("ready_after_reset_1", W'(s1_tready), W'(1));
    check("ready_after_reset_2", W'(s2_tready), W'(1));

    // basic pair: visible one edge after both beats transfer
    p1 = '{8'd3}; p2 = '{8'd5}; en1 = 1; en2 = 1; mr = 1;
    tick();
    tick();
    check("basic_d1", data1_o, 8'd3);
    check("basic_d2", data2_o, 8'd5);
    check("basic_valid", W'(m_tvalid), W'(1));

    // skew: s1 runs ahead while s2 idles
    en2 = 0;
    p1 = '{8'd1, 8'd2, 8'd3};
    repeat (4) tick();
    check("skew_s1_ready", W'(s1_tready), W'(0));
    check("skew_s2_ready", W'(s2_tready), W'(1));
    check("skew_valid", W'(m_tvalid), W'(0));
    got.delete();
    p2 = '{8'd10, 8'd20, 8'd30}; en2 = 1;
    repeat (8) tick();
    c1 = '{8'd1, 8'd2, 8'd3}; c2 = '{8'd10, 8'd20, 8'd30};
    check_pairs("skew");

    // backpressure with both inputs streaming
    got.delete(); c1.delete(); c2.delete();
    for (int unsigned i = 0; i < 6; i++) begin
      c1.push_back(W'($urandom)); c2.push_back(W'($urandom));
    end
    p1 = c1; p2 = c2; mr = 0;
    repeat (5) tick();
    check("bp_s1_ready", W'(s1_tready), W'(0));
    check("bp_s2_ready", W'(s2_tready), W'(0));
    check("bp_valid", W'(m_tvalid), W'(1));
    check("bp_head_d1", data1_o, c1[0]);
    mr = 1;
    repeat (12) tick();
    check_pairs("bp");

    // full-rate streaming
    got.delete(); c1.delete(); c2.delete(); hs_count = 0;
    for (int unsigned i = 0; i < 100; i++) begin
      c1.push_back(W'($urandom)); c2.push_back(W'($urandom));
    end
    p1 = c1; p2 = c2;
    repeat (102) tick();
    check("stream_rate", W'(hs_count), W'(100));
    check_pairs("stream");

    // reset while both buffers are full and a pair is held
    mr = 0;
    for (int unsigned i = 0; i < 6; i++) begin
      p1.push_back(W'($urandom)); p2.push_back(W'($urandom));
    end
    repeat (5) tick();
    check("midrst_pre_valid", W'(m_tvalid), W'(1));
    do_reset(3);
    check("midrst_valid", W'(m_tvalid), W'(0));
    got.delete();
    p1 = '{8'd7}; p2 = '{8'd9}; en1 = 1; en2 = 1; mr = 1;
    repeat (4) tick();
    c1 = '{8'd7}; c2 = '{8'd9};
    check_pairs("midrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
